// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryption core: one round per clock, with round keys
// derived backward on the fly from a stored round-10 key.
module aes_inv_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         kdone,
  output logic         done,
  output logic [127:0] text_out
);

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_READY, S_DEC} state_t;

  state_t       state_q, state_d;
  logic [127:0] rk10_q, rk10_d;
  logic [127:0] wk_q, wk_d;
  logic [127:0] st_q, st_d;
  logic [127:0] text_out_q, text_out_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;
  logic         kdone_q, kdone_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return {1'b0, b[7:1]} ^ (b[0] ? 8'h8d : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] x);
    logic [7:0] a0, a1, a2, a3;
    a0 = x[31:24];
    a1 = x[23:16];
    a2 = x[15:8];
    a3 = x[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [31:0]  w0, w1, w2, w3, w3_bk;
  logic [31:0]  sw_in, sw_rot, sw_out;
  logic [31:0]  f0, f1, f2, f3, b0;
  logic [127:0] fwd_key, bwd_key;

  assign w0 = wk_q[127:96];
  assign w1 = wk_q[95:64];
  assign w2 = wk_q[63:32];
  assign w3 = wk_q[31:0];
  assign w3_bk = w3 ^ w2;

  // One SubWord unit serves both directions: forward uses w3, backward the recovered w3.
  assign sw_in  = (state_q == S_DEC) ? w3_bk : w3;
  assign sw_rot = {sw_in[23:0], sw_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign sw_out[31-8*gi -: 8] = sbox(sw_rot[31-8*gi -: 8]);
    end
  endgenerate

  assign f0 = w0 ^ sw_out ^ {rcon_q, 24'h000000};
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  assign b0 = w0 ^ sw_out ^ {rcon_q, 24'h000000};
  assign bwd_key = {b0, w1 ^ w0, w2 ^ w1, w3_bk};

  logic [127:0] isr_isb, ark, imc, round_out;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_shift_sub
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr_isb[127-8*gi -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
    end
  endgenerate

  assign ark = isr_isb ^ bwd_key;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
      assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
    end
  endgenerate

  assign round_out = (rcnt_q == 4'd0) ? ark : imc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rk10_q     <= '0;
      wk_q       <= '0;
      st_q       <= '0;
      text_out_q <= '0;
      rcnt_q     <= '0;
      rcon_q     <= '0;
      done_q     <= 1'b0;
      kdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk10_q     <= rk10_d;
      wk_q       <= wk_d;
      st_q       <= st_d;
      text_out_q <= text_out_d;
      rcnt_q     <= rcnt_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
      kdone_q    <= kdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kld) begin
      state_d = S_KEXP;
    end else begin
      case (state_q)
        S_KEXP:  if (rcnt_q == 4'd9) state_d = S_READY;
        S_READY: if (ld) state_d = S_DEC;
        S_DEC:   if (rcnt_q == 4'd0) state_d = S_READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rk10_d     = rk10_q;
    wk_d       = wk_q;
    st_d       = st_q;
    text_out_d = text_out_q;
    rcnt_d     = rcnt_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    kdone_d    = 1'b0;
    if (kld) begin
      wk_d   = key;
      rcon_d = 8'h01;
      rcnt_d = 4'd0;
    end else begin
      case (state_q)
        S_KEXP: begin
          wk_d   = fwd_key;
          rcon_d = xtime(rcon_q);
          rcnt_d = rcnt_q + 4'd1;
          if (rcnt_q == 4'd9) begin
            rk10_d  = fwd_key;
            kdone_d = 1'b1;
          end
        end
        S_READY: begin
          if (ld) begin
            st_d   = text_in ^ rk10_q;
            wk_d   = rk10_q;
            rcon_d = 8'h36;
            rcnt_d = 4'd9;
          end
        end
        S_DEC: begin
          st_d   = round_out;
          wk_d   = bwd_key;
          rcon_d = inv_xtime(rcon_q);
          if (rcnt_q == 4'd0) begin
            text_out_d = round_out;
            done_d     = 1'b1;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign kdone    = kdone_q;
  assign done     = done_q;
  assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: transaction-level AES model with a per-cycle
// output comparison, plus FIPS-197 vectors and round-trip blocks.
module tb_aes_inv_cipher_top;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         kld = 1'b0;
  logic         ld = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] text_in = '0;
  logic         kdone, done;
  logic [127:0] text_out;

  aes_inv_cipher_top dut (
    .clk(clk), .rst(rst), .kld(kld), .ld(ld), .key(key), .text_in(text_in),
    .kdone(kdone), .done(done), .text_out(text_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // Tables built by walking generator 3 and its inverse, not by per-byte inversion.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] ww [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) ww[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ww[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      ww[i] = ww[i-4] ^ t;
    end
    return {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[v[127-8*i -: 8]] : sb[v[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = v[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc ^= gm(cf[(k - r + 4) % 4], v[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ round_key(k, 10);
    for (int r = 9; r >= 1; r--) s = mix_c(sub_b(shift_r(s, 1'b1), 1'b1) ^ round_key(k, r), 1'b1);
    return sub_b(shift_r(s, 1'b1), 1'b1) ^ round_key(k, 0);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key(k, 0);
    for (int r = 1; r <= 9; r++) s = mix_c(shift_r(sub_b(s, 1'b0), 1'b0), 1'b0) ^ round_key(k, r);
    return shift_r(sub_b(s, 1'b0), 1'b0) ^ round_key(k, 10);
  endfunction

  // Transaction model: countdown timers for expansion and decryption.
  bit           m_key_ok = 0, m_done = 0, m_kdone = 0;
  int           m_kexp_left = 0, m_dec_left = 0;
  logic [127:0] m_key = '0, m_dec_val = '0, m_text = '0;

  initial begin
    bit busy, ok;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_key_ok = 0; m_done = 0; m_kdone = 0;
        m_kexp_left = 0; m_dec_left = 0; m_text = '0;
      end else begin
        busy = (m_kexp_left > 0) || (m_dec_left > 0);
        ok = m_key_ok;
        m_done = 0; m_kdone = 0;
        if (kld) begin
          m_kexp_left = 10; m_key_ok = 0; m_dec_left = 0; m_key = key;
        end else begin
          if (m_kexp_left > 0) begin
            m_kexp_left--;
            if (m_kexp_left == 0) begin m_kdone = 1; m_key_ok = 1; end
          end
          if (m_dec_left > 0) begin
            m_dec_left--;
            if (m_dec_left == 0) begin m_done = 1; m_text = m_dec_val; end
          end
          if (ld && ok && !busy) begin
            m_dec_left = 10;
            m_dec_val = aes_dec(m_key, text_in);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) check("reset_outputs", {done, kdone, text_out}, '0);
      else      check("cycle_outputs", {done, kdone, text_out}, {m_done, m_kdone, m_text});
    end
  end

  task automatic pulse_kld(input logic [127:0] k);
    $display("txn kld key=%h", k);
    kld = 1'b1; key = k;
    @(negedge clk);
    kld = 1'b0;
  endtask

  task automatic pulse_ld(input logic [127:0] d);
    $display("txn ld  ct=%h", d);
    ld = 1'b1; text_in = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_pulse(input bit on_done, input string name);
    int  c;
    bit  seen;
    c = 0; seen = 0;
    while (c < 20 && !seen) begin
      @(negedge clk);
      c++;
      seen = on_done ? done : kdone;
    end
    check(name, 130'(c), 130'd10);
    if (on_done) $display("txn done pt=%h after %0d cycles", text_out, c);
  endtask

  initial begin
    logic [127:0] rk, rp, rc;
    build_tables();
    check("sbox_00", 130'(sb[8'h00]), 130'h63);
    check("sbox_53", 130'(sb[8'h53]), 130'hed);
    check("model_rk10_k1", 130'(round_key(K1, 10)), 130'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_rk10_k2", 130'(round_key(K2, 10)), 130'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_dec_v1", 130'(aes_dec(K1, CT1)), 130'(PT1));
    check("model_enc_v2", 130'(aes_enc(K2, PT2)), 130'(CT2));

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    pulse_ld(CT1);
    repeat (15) @(negedge clk);
    check("nokey_text_out", 130'(text_out), '0);

    pulse_kld(K1);
    wait_pulse(1'b0, "kdone_latency_k1");
    pulse_ld(CT1);
    wait_pulse(1'b1, "done_latency_v1");
    check("pt_v1", 130'(text_out), 130'(PT1));

    pulse_kld(K2);
    wait_pulse(1'b0, "kdone_latency_k2");
    pulse_ld(CT2);
    wait_pulse(1'b1, "done_latency_v2");
    check("pt_v2", 130'(text_out), 130'(PT2));
    pulse_ld(CT2);
    wait_pulse(1'b1, "done_latency_b2b");
    check("pt_v2_b2b", 130'(text_out), 130'(PT2));

    pulse_ld(CT1);
    repeat (4) @(negedge clk);
    pulse_kld(K1);
    wait_pulse(1'b0, "kdone_after_abort");
    check("text_after_abort", 130'(text_out), 130'(PT2));

    $display("txn kld+ld key=%h ct=%h", K1, CT1);
    kld = 1'b1; ld = 1'b1; key = K1; text_in = CT1;
    @(negedge clk);
    kld = 1'b0; ld = 1'b0;
    wait_pulse(1'b0, "kdone_kld_ld");
    repeat (12) @(negedge clk);
    check("text_after_kld_ld", 130'(text_out), 130'(PT2));

    pulse_ld(CT1);
    wait_pulse(1'b1, "done_latency_v1b");
    check("pt_v1b", 130'(text_out), 130'(PT1));

    pulse_ld(CT2);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst_async_clear", {done, kdone, text_out}, '0);
    $display("txn rst pulse mid-decrypt");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_ld(CT1);
    repeat (15) @(negedge clk);
    check("text_after_rst", 130'(text_out), '0);
    pulse_kld(K1);
    wait_pulse(1'b0, "kdone_after_rst");
    pulse_ld(CT1);
    wait_pulse(1'b1, "done_after_rst");
    check("pt_after_rst", 130'(text_out), 130'(PT1));

    for (int i = 0; i < 8; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = aes_enc(rk, rp);
      pulse_kld(rk);
      wait_pulse(1'b0, "kdone_roundtrip");
      pulse_ld(rc);
      wait_pulse(1'b1, "done_roundtrip");
      check("pt_roundtrip", 130'(text_out), 130'(rp));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
